// File: rtl/float_fmt_pkg.sv
// Shared float format helpers for the byte feeder and the float-to-fixed converter.
package float_fmt_pkg;

    localparam int BYTES_PER_WORD_FLOAT  = 4;
    localparam int BYTES_PER_WORD_DOUBLE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2
    } feeder_state_t;

    function automatic int float_wid(input string fmt);
        return (fmt == "float") ? 32 : 64;
    endfunction

    function automatic int exp_wid(input string fmt);
        return (fmt == "float") ? 8 : 11;
    endfunction

    function automatic int mant_wid(input string fmt);
        return (fmt == "float") ? 23 : 52;
    endfunction

    function automatic int bytes_per_word(input string fmt);
        return (fmt == "float") ? BYTES_PER_WORD_FLOAT : BYTES_PER_WORD_DOUBLE;
    endfunction

endpackage

// File: rtl/float_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded on every accepted byte, expires at terminal count.
module float_gap_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Expires during the TIMEOUT-th idle cycle after the last reload.
    assign expire = run && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/float_byte_feeder.sv
// Assembles an IEEE754 word from a byte stream and drives the converter enable window.
// state   | meaning
// IDLE    | waiting for the first byte of a word
// COLLECT | filling the shadow word, gap timer running
// ISSUE   | conv_en window open, watching for conv_done
module float_byte_feeder
    import float_fmt_pkg::*;
#(
    parameter string FLOAT_FMT   = "double",
    parameter string BYTE_ORDER  = "LSB_FIRST",
    parameter int    EN_CYCLES   = 9,
    parameter int    GAP_TIMEOUT = 1024,
    localparam int   FLOAT_WID   = float_wid(FLOAT_FMT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    input  logic                 abort,
    output logic [FLOAT_WID-1:0] float_val,
    output logic                 conv_en,
    input  logic                 conv_done,
    output logic                 word_done,
    output logic                 conv_err,
    output logic                 frame_err,
    output logic [15:0]          word_cnt
);

    localparam int BPW       = FLOAT_WID / 8;
    localparam int IDX_W     = $clog2(BPW);
    localparam int EN_W      = $clog2(EN_CYCLES + 1);
    localparam bit MSB_FIRST = (BYTE_ORDER == "MSB_FIRST");
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

    feeder_state_t          state, state_d;
    logic [FLOAT_WID-1:0]   shadow, shadow_d, merged, float_d;
    logic [IDX_W-1:0]       idx, idx_d, pos;
    logic [EN_W-1:0]        en_cnt, en_cnt_d;
    logic                   done_seen, seen_d, window_hit;
    logic                   conv_en_d, word_done_d, conv_err_d, frame_err_d, byte_ready_d;
    logic [15:0]            word_cnt_d;
    logic                   accept, tmr_load, tmr_clear, tmr_run, tmr_expire;

    assign accept  = byte_valid && byte_ready;
    assign tmr_run = (state == ST_COLLECT) && !accept && !abort;

    float_gap_timer #(
        .TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            idx        <= '0;
            float_val  <= '0;
            conv_en    <= 1'b0;
            en_cnt     <= '0;
            done_seen  <= 1'b0;
            word_done  <= 1'b0;
            conv_err   <= 1'b0;
            frame_err  <= 1'b0;
            word_cnt   <= '0;
            byte_ready <= 1'b0;
        end else begin
            state      <= state_d;
            shadow     <= shadow_d;
            idx        <= idx_d;
            float_val  <= float_d;
            conv_en    <= conv_en_d;
            en_cnt     <= en_cnt_d;
            done_seen  <= seen_d;
            word_done  <= word_done_d;
            conv_err   <= conv_err_d;
            frame_err  <= frame_err_d;
            word_cnt   <= word_cnt_d;
            byte_ready <= byte_ready_d;
        end
    end

    always_comb begin
        state_d     = state;
        shadow_d    = shadow;
        idx_d       = idx;
        float_d     = float_val;
        conv_en_d   = conv_en;
        en_cnt_d    = en_cnt;
        seen_d      = done_seen;
        word_done_d = 1'b0;
        conv_err_d  = 1'b0;
        frame_err_d = 1'b0;
        word_cnt_d  = word_cnt;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        window_hit  = done_seen || conv_done;

        pos    = MSB_FIRST ? (IDX_LAST - idx) : idx;
        merged = shadow;
        merged[{pos, 3'b000} +: 8] = byte_data;

        if (abort) begin
            state_d   = ST_IDLE;
            shadow_d  = '0;
            idx_d     = '0;
            conv_en_d = 1'b0;
            en_cnt_d  = '0;
            seen_d    = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            float_d   = merged;
                            shadow_d  = '0;
                            idx_d     = '0;
                            conv_en_d = 1'b1;
                            en_cnt_d  = EN_W'(EN_CYCLES);
                            seen_d    = 1'b0;
                            tmr_clear = 1'b1;
                            state_d   = ST_ISSUE;
                        end else begin
                            shadow_d = merged;
                            idx_d    = idx + IDX_W'(1);
                            tmr_load = 1'b1;
                            state_d  = ST_COLLECT;
                        end
                    end else if (tmr_expire) begin
                        shadow_d    = '0;
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                        tmr_clear   = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (conv_done) begin
                        seen_d = 1'b1;
                    end
                    if (en_cnt == EN_W'(1)) begin
                        conv_en_d   = 1'b0;
                        en_cnt_d    = '0;
                        seen_d      = 1'b0;
                        word_done_d = window_hit;
                        conv_err_d  = !window_hit;
                        if (window_hit) begin
                            word_cnt_d = word_cnt + 16'd1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        en_cnt_d = en_cnt - EN_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        byte_ready_d = (state_d != ST_ISSUE);
    end

endmodule

// File: tb/tb_float_byte_feeder.sv
// Directed bench for float_byte_feeder: double/LSB_FIRST instance plus a float/MSB_FIRST instance.
module tb_float_byte_feeder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        abort = 1'b0;
    logic        conv_done = 1'b0;
    logic        byte_ready, conv_en, word_done, conv_err, frame_err;
    logic [63:0] float_val;
    logic [15:0] word_cnt;

    logic        f_valid = 1'b0;
    logic [7:0]  f_data = 8'h00;
    logic        f_ready, f_conv_en, f_word_done, f_conv_err, f_frame_err;
    logic [31:0] f_float_val;
    logic [15:0] f_word_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_byte_feeder #(
        .FLOAT_FMT   ("double"),
        .BYTE_ORDER  ("LSB_FIRST"),
        .EN_CYCLES   (9),
        .GAP_TIMEOUT (16)
    ) dut_d (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .abort      (abort),
        .float_val  (float_val),
        .conv_en    (conv_en),
        .conv_done  (conv_done),
        .word_done  (word_done),
        .conv_err   (conv_err),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt)
    );

    float_byte_feeder #(
        .FLOAT_FMT   ("float"),
        .BYTE_ORDER  ("MSB_FIRST")
    ) dut_f (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (f_valid),
        .byte_data  (f_data),
        .byte_ready (f_ready),
        .abort      (1'b0),
        .float_val  (f_float_val),
        .conv_en    (f_conv_en),
        .conv_done  (1'b0),
        .word_done  (f_word_done),
        .conv_err   (f_conv_err),
        .frame_err  (f_frame_err),
        .word_cnt   (f_word_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input bit to_f, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        if (to_f) begin
            f_valid = 1'b1;
            f_data  = b;
        end else begin
            byte_valid = 1'b1;
            byte_data  = b;
        end
        while (!(to_f ? f_ready : byte_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        f_valid    = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) send_byte(1'b0, w[8*i +: 8]);
    endtask

    // Runs the 9-cycle window after a completed word, optionally pulsing conv_done in cycle 7.
    task automatic run_window(input logic [63:0] exp_w, input bit give_done, input logic [15:0] exp_cnt);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) check_val("float_val_load", float_val, exp_w);
            check_val("conv_en_window", 64'(conv_en), 64'd1);
            check_val("ready_in_window", 64'(byte_ready), 64'd0);
            conv_done = give_done && (k == 7);
        end
        @(negedge clk);
        conv_done = 1'b0;
        check_val("conv_en_fall", 64'(conv_en), 64'd0);
        check_val("word_done_pulse", 64'(word_done), 64'(give_done));
        check_val("conv_err_pulse", 64'(conv_err), 64'(!give_done));
        check_val("word_cnt", 64'(word_cnt), 64'(exp_cnt));
        check_val("ready_after", 64'(byte_ready), 64'd1);
        @(negedge clk);
        check_val("pulse_end", 64'({word_done, conv_err}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fe_sum, fe_first, bad;

        #12;
        check_val("rst_float_val", float_val, 64'd0);
        check_val("rst_outputs", 64'({byte_ready, conv_en, word_done, conv_err, frame_err}), 64'd0);
        check_val("rst_word_cnt", 64'(word_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", 64'(byte_ready), 64'd1);

        send_word(64'h3FF0000000000000);
        run_window(64'h3FF0000000000000, 1'b1, 16'd1);
        send_word(64'h3FF0000000000000);
        run_window(64'h3FF0000000000000, 1'b0, 16'd1);

        // gap timeout after 3 bytes
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        send_byte(1'b0, 8'h33);
        fe_sum = 0;
        fe_first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_err) begin
                fe_sum++;
                if (fe_first == 0) fe_first = k;
            end
        end
        check_val("frame_err_count", 64'(fe_sum), 64'd1);
        check_val("frame_err_cycle", 64'(fe_first), 64'd17);
        check_val("float_val_kept_gap", float_val, 64'h3FF0000000000000);
        send_word(64'h400921FB54442D18);
        run_window(64'h400921FB54442D18, 1'b1, 16'd2);

        // abort in window cycle 3
        send_word(64'hC000000000000000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            conv_done = (k == 2);
            abort = (k == 3);
        end
        @(negedge clk);
        abort = 1'b0;
        conv_done = 1'b0;
        check_val("abort_conv_en", 64'(conv_en), 64'd0);
        check_val("abort_ready", 64'(byte_ready), 64'd1);
        check_val("abort_float_val", float_val, 64'hC000000000000000);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (word_done || conv_err || conv_en) bad++;
        end
        check_val("abort_no_pulse", 64'(bad), 64'd0);
        check_val("abort_word_cnt", 64'(word_cnt), 64'd2);

        // abort with a byte mid-word: byte dropped, index restarts
        send_byte(1'b0, 8'hAA);
        send_byte(1'b0, 8'hBB);
        send_byte(1'b0, 8'hCC);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'hDD;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        abort      = 1'b0;
        send_word(64'h0123456789ABCDEF);
        run_window(64'h0123456789ABCDEF, 1'b1, 16'd3);

        // float, MSB_FIRST
        send_byte(1'b1, 8'h41);
        send_byte(1'b1, 8'hE0);
        send_byte(1'b1, 8'h53);
        send_byte(1'b1, 8'hC8);
        @(negedge clk);
        check_val("f_float_val", 64'(f_float_val), 64'h41E053C8);
        check_val("f_conv_en", 64'(f_conv_en), 64'd1);

        // reset mid-word
        for (int i = 0; i < 5; i++) send_byte(1'b0, 8'h5A);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_val("midrst_float_val", float_val, 64'd0);
        check_val("midrst_outputs", 64'({byte_ready, conv_en, word_done, conv_err, frame_err}), 64'd0);
        check_val("midrst_word_cnt", 64'(word_cnt), 64'd0);
        check_val("midrst_f_float_val", 64'(f_float_val), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        send_word(64'hFEDCBA9876543210);
        run_window(64'hFEDCBA9876543210, 1'b1, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
